ps2_kbd_device_tx: RTL and testbench

//  Simulation/test-side PS/2 keyboard device: serialises queued scancode bytes onto an open-drain
//  PS/2 clock/data pair, acting as the far end of the system's PS/2 keyboard receiver. The device

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 56 +++++
 rtl/ps2_kbd_device_tx.sv | 197 +++++++++++++++++++
 tb/tb_ps2_kbd_device_tx.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard device transmitter.
//   ps2_tx_state_t  : transmit FSM states
//   PS2_FRAME_BITS  : start + 8 data + parity + stop
//   odd_parity()    : parity bit that makes the 9-bit data+parity field odd
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BUS,
    ST_SETUP,
    ST_CLK_LOW,
    ST_CLK_HIGH,
    ST_GAP
  } ps2_tx_state_t;

  localparam int unsigned PS2_FRAME_BITS = 11;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO used as the scancode queue.
//   clk, rst_n : clock, asynchronous active-low reset (empties the queue)
//   push, wr_data : write request/data, ignored while full
//   pop        : read request, ignored while empty
//   rd_data    : current head entry (show-ahead)
//   full, empty: occupancy flags
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_device_tx.sv
// PS/2 keyboard device side: serialises queued scancodes onto an open-drain
// PS/2 clock/data pair, generating the clock itself and backing off when the
// host inhibits the bus. Aborted bytes stay queued and are resent in full.
//   clk, reset_n_i    : system clock, asynchronous active-low reset
//   data_i, valid_i   : scancode byte in, pushed when valid_i && ready_o
//   ready_o           : queue not full
//   ps2_clk_i/data_i  : wire levels (asynchronous, synchronised here)
//   ps2_clk_oe_o      : 1 = pull PS/2 clock low
//   ps2_data_oe_o     : 1 = pull PS/2 data low
//   busy_o            : frame in progress
//   abort_o           : one-cycle pulse when host inhibit abandons a frame
module ps2_kbd_device_tx
  import ps2_pkg::*;
#(
  parameter int unsigned HALF_CYC   = 1250,
  parameter int unsigned IDLE_CYC   = 2500,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset_n_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o,
  output logic       busy_o,
  output logic       abort_o
);

  localparam int unsigned CNT_MAX = (HALF_CYC > IDLE_CYC) ? HALF_CYC : IDLE_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYC - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(HALF_CYC / 2 - 1);
  localparam logic [CW-1:0] IDLE_LAST  = CW'(IDLE_CYC - 1);
  // The synchroniser still shows our own low phase for the first two
  // cycles after release; clock-low is only trusted from here on.
  localparam logic [CW-1:0] INH_START  = CW'(2);
  localparam logic [3:0]    STOP_IDX   = 4'(PS2_FRAME_BITS - 1);

  ps2_tx_state_t              state;
  logic [CW-1:0]              cnt;
  logic [3:0]                 idx;
  logic [3:0]                 next_idx;
  logic [PS2_FRAME_BITS-1:0]  frame;
  logic [1:0]                 clk_sync;
  logic [1:0]                 data_sync;
  logic                       clk_s;
  logic                       data_s;
  logic                       clk_oe;
  logic                       data_oe;
  logic                       abort;

  logic                       fifo_push;
  logic                       fifo_pop;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [7:0]                 fifo_head;

  assign fifo_push = valid_i && !fifo_full;
  // Pop once, on the first GAP cycle: the stop bit has fully completed.
  assign fifo_pop  = (state == ST_GAP) && (cnt == '0);
  assign ready_o   = !fifo_full;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n_i),
    .push    (fifo_push),
    .wr_data (data_i),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_i};
      data_sync <= {data_sync[0], ps2_data_i};
    end
  end

  assign clk_s    = clk_sync[1];
  assign data_s   = data_sync[1];
  assign next_idx = idx + 4'd1;

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      idx     <= '0;
      frame   <= '0;
      clk_oe  <= 1'b0;
      data_oe <= 1'b0;
      abort   <= 1'b0;
    end else begin
      abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            frame <= {1'b1, odd_parity(fifo_head), fifo_head, 1'b0};
            cnt   <= '0;
            state <= ST_WAIT_BUS;
          end
        end

        ST_WAIT_BUS: begin
          if (!clk_s || !data_s) begin
            cnt <= '0;
          end else if (cnt == IDLE_LAST) begin
            cnt     <= '0;
            idx     <= '0;
            data_oe <= ~frame[0];
            state   <= ST_SETUP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt    <= '0;
            clk_oe <= 1'b1;
            state  <= ST_CLK_LOW;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_CLK_LOW: begin
          if (cnt == HALF_LAST) begin
            cnt    <= '0;
            clk_oe <= 1'b0;
            state  <= ST_CLK_HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_CLK_HIGH: begin
          // Inhibit during the stop bit is ignored: the byte counts as sent.
          if ((idx != STOP_IDX) && (cnt >= INH_START) && !clk_s) begin
            cnt     <= '0;
            clk_oe  <= 1'b0;
            data_oe <= 1'b0;
            abort   <= 1'b1;
            state   <= ST_WAIT_BUS;
          end else if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (idx == STOP_IDX) begin
              data_oe <= 1'b0;
              state   <= ST_GAP;
            end else begin
              idx     <= next_idx;
              data_oe <= ~frame[next_idx];
              state   <= ST_SETUP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_GAP: begin
          clk_oe  <= 1'b0;
          data_oe <= 1'b0;
          if (cnt == IDLE_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state   <= ST_IDLE;
          cnt     <= '0;
          clk_oe  <= 1'b0;
          data_oe <= 1'b0;
        end
      endcase
    end
  end

  assign ps2_clk_oe_o  = clk_oe;
  assign ps2_data_oe_o = data_oe;
  assign busy_o        = (state != ST_IDLE);
  assign abort_o       = abort;

endmodule

// File: tb/tb_ps2_kbd_device_tx.sv
module tb_ps2_kbd_device_tx;

  localparam int unsigned HALF_CYC   = 4;
  localparam int unsigned IDLE_CYC   = 8;
  localparam int unsigned FIFO_DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset_n_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic       ps2_clk_oe_o;
  logic       ps2_data_oe_o;
  logic       busy_o;
  logic       abort_o;
  logic       host_clk_low = 1'b0;
  logic       host_data_low = 1'b0;
  logic       ps2_clk;
  logic       ps2_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int abort_cycles = 0;
  int stab_err = 0;

  bit bits[$];
  int edge_cyc[$];

  // Open-drain wires with pull-ups.
  assign ps2_clk  = !(ps2_clk_oe_o || host_clk_low);
  assign ps2_data = !(ps2_data_oe_o || host_data_low);

  ps2_kbd_device_tx #(
    .HALF_CYC   (HALF_CYC),
    .IDLE_CYC   (IDLE_CYC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .reset_n_i     (reset_n_i),
    .data_i        (data_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .ps2_clk_i     (ps2_clk),
    .ps2_data_i    (ps2_data),
    .ps2_clk_oe_o  (ps2_clk_oe_o),
    .ps2_data_oe_o (ps2_data_oe_o),
    .busy_o        (busy_o),
    .abort_o       (abort_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Host-side receiver: sample data on device-generated falling clock edges.
  always @(negedge ps2_clk) begin
    if (reset_n_i && !host_clk_low) begin
      bits.push_back(ps2_data);
      edge_cyc.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (abort_o) abort_cycles = abort_cycles + 1;
  end

  // Data may only change while the device is not holding the clock low.
  always @(ps2_data_oe_o) begin
    if (reset_n_i && ps2_clk_oe_o) stab_err = stab_err + 1;
  end

  // Expected 11-bit frame, bit 0 first on the wire.
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic [10:0] f;
    for (int i = 0; i < 11; i++) begin
      if (i == 0)       f[i] = 1'b0;
      else if (i <= 8)  f[i] = b[i-1];
      else if (i == 9)  f[i] = (($countones(b) % 2) == 0);
      else              f[i] = 1'b1;
    end
    return f;
  endfunction

  function automatic logic [10:0] got_frame(input int base);
    logic [10:0] f;
    for (int i = 0; i < 11; i++) begin
      if (base + i < bits.size()) f[i] = bits[base + i];
      else                        f[i] = 1'bx;
    end
    return f;
  endfunction

  task automatic wait_bits(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bits.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (bits.size() >= n) ok = 1'b1;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_clk_oe(input logic level, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ps2_clk_oe_o == level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic push_byte(input logic [7:0] b, input int budget, output bit ok,
                           output int bits_at_accept);
    ok = 1'b0;
    bits_at_accept = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      valid_i = 1'b1;
      data_i  = b;
      if (ready_o) begin
        bits_at_accept = bits.size();
        @(posedge clk);
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic end_push();
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ps2_clk_oe_o !== 1'b0 || ps2_data_oe_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_oe: clk_oe=%b data_oe=%b required 0 0", ps2_clk_oe_o, ps2_data_oe_o);
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b required 1", ready_o);
    end
    checks++;
    if (busy_o !== 1'b0 || abort_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_abort: busy=%b abort=%b required 0 0", busy_o, abort_o);
    end
    reset_n_i = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    int acc;
    bits.delete();
    edge_cyc.delete();
    push_byte(8'h1C, 4, ok, acc);
    end_push();
    wait_bits(11, 600, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_timeout: got %0d bits required 11", bits.size());
    end
    checks++;
    if (got_frame(0) !== exp_frame(8'h1C)) begin
      errors++;
      $display("FAIL single_frame: got %b required %b", got_frame(0), exp_frame(8'h1C));
    end
    wait_idle(200, ok);
    checks++;
    if (!ok || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_end: busy=%b required 0", busy_o);
    end
    repeat (300) @(negedge clk);
    checks++;
    if (bits.size() != 11) begin
      errors++;
      $display("FAIL single_one_pop: got %0d bits required 11", bits.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int acc;
    logic [7:0] q[$];
    bits.delete();
    edge_cyc.delete();
    q.push_back(8'h00);
    q.push_back(8'hFF);
    q.push_back(8'($urandom));
    q.push_back(8'($urandom));
    foreach (q[k]) push_byte(q[k], 4, ok, acc);
    end_push();
    wait_bits(44, 2400, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d bits required 44", bits.size());
    end
    foreach (q[k]) begin
      checks++;
      if (got_frame(11 * k) !== exp_frame(q[k])) begin
        errors++;
        $display("FAIL b2b_frame%0d: got %b required %b", k, got_frame(11 * k), exp_frame(q[k]));
      end
    end
    checks++;
    if (bits.size() >= 12 && (edge_cyc[11] - edge_cyc[10]) < int'(IDLE_CYC)) begin
      errors++;
      $display("FAIL b2b_gap: got %0d cycles required >= %0d", edge_cyc[11] - edge_cyc[10], IDLE_CYC);
    end
    wait_idle(400, ok);
  endtask

  task automatic test_fifo_full();
    bit ok;
    bit ok9;
    int acc;
    int acc9;
    logic [7:0] q[$];
    logic [7:0] b9;
    bits.delete();
    edge_cyc.delete();
    @(negedge clk);
    host_clk_low = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < int'(FIFO_DEPTH); k++) begin
      q.push_back(8'($urandom));
      push_byte(q[k], 4, ok, acc);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL full_push%0d: accepted=%b required 1", k, ok);
      end
    end
    end_push();
    checks++;
    if (ready_o !== (q.size() < FIFO_DEPTH)) begin
      errors++;
      $display("FAIL full_ready: got %b required %b", ready_o, q.size() < FIFO_DEPTH);
    end
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL full_wait_bus: busy=%b required 1", busy_o);
    end
    b9 = 8'($urandom);
    fork
      push_byte(b9, 3000, ok9, acc9);
      begin
        repeat (20) @(negedge clk);
        host_clk_low = 1'b0;
      end
    join
    end_push();
    q.push_back(b9);
    checks++;
    if (!ok9 || acc9 < 11) begin
      errors++;
      $display("FAIL full_ninth_hold: accepted=%b bits_at_accept=%0d required 1 and >= 11", ok9, acc9);
    end
    wait_bits(99, 4500, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL full_timeout: got %0d bits required 99", bits.size());
    end
    foreach (q[k]) begin
      checks++;
      if (got_frame(11 * k) !== exp_frame(q[k])) begin
        errors++;
        $display("FAIL full_frame%0d: got %b required %b", k, got_frame(11 * k), exp_frame(q[k]));
      end
    end
    wait_idle(400, ok);
  endtask

  task automatic test_abort();
    bit ok;
    bit seen;
    int acc;
    int a0;
    bits.delete();
    edge_cyc.delete();
    a0 = abort_cycles;
    push_byte(8'hAA, 4, ok, acc);
    end_push();
    wait_bits(5, 600, ok);
    wait_clk_oe(1'b0, 20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL abort_reach_bit4: bits=%0d clk_oe=%b required 5 and 0", bits.size(), ps2_clk_oe_o);
    end
    host_clk_low = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (abort_o) begin
        seen = 1'b1;
        checks++;
        if (ps2_clk_oe_o !== 1'b0 || ps2_data_oe_o !== 1'b0) begin
          errors++;
          $display("FAIL abort_release: clk_oe=%b data_oe=%b required 0 0", ps2_clk_oe_o, ps2_data_oe_o);
        end
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL abort_pulse_seen: got 0 required 1");
    end
    bits.delete();
    edge_cyc.delete();
    repeat (8) @(negedge clk);
    host_clk_low = 1'b0;
    checks++;
    if (abort_cycles - a0 != 1) begin
      errors++;
      $display("FAIL abort_pulse_width: got %0d cycles required 1", abort_cycles - a0);
    end
    wait_bits(11, 800, ok);
    checks++;
    if (got_frame(0) !== exp_frame(8'hAA)) begin
      errors++;
      $display("FAIL abort_retry: got %b required %b", got_frame(0), exp_frame(8'hAA));
    end
    wait_idle(400, ok);
    repeat (100) @(negedge clk);
    checks++;
    if (bits.size() != 11 || abort_cycles - a0 != 1) begin
      errors++;
      $display("FAIL abort_after: bits=%0d aborts=%0d required 11 1", bits.size(), abort_cycles - a0);
    end
  endtask

  task automatic test_stop_inhibit();
    bit ok;
    int acc;
    int a0;
    logic [7:0] b1;
    logic [7:0] b2;
    bits.delete();
    edge_cyc.delete();
    a0 = abort_cycles;
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    push_byte(b1, 4, ok, acc);
    push_byte(b2, 4, ok, acc);
    end_push();
    wait_bits(11, 600, ok);
    wait_clk_oe(1'b0, 20, ok);
    host_clk_low = 1'b1;
    repeat (3) @(negedge clk);
    host_clk_low = 1'b0;
    wait_bits(22, 800, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stop_inh_timeout: got %0d bits required 22", bits.size());
    end
    checks++;
    if (got_frame(0) !== exp_frame(b1) || got_frame(11) !== exp_frame(b2)) begin
      errors++;
      $display("FAIL stop_inh_frames: got %b %b required %b %b",
               got_frame(0), got_frame(11), exp_frame(b1), exp_frame(b2));
    end
    checks++;
    if (abort_cycles != a0) begin
      errors++;
      $display("FAIL stop_inh_no_abort: got %0d aborts required 0", abort_cycles - a0);
    end
    wait_idle(400, ok);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int acc;
    bits.delete();
    edge_cyc.delete();
    push_byte(8'($urandom), 4, ok, acc);
    push_byte(8'($urandom), 4, ok, acc);
    end_push();
    wait_bits(3, 600, ok);
    wait_clk_oe(1'b1, 20, ok);
    reset_n_i = 1'b0;
    #1;
    checks++;
    if (ps2_clk_oe_o !== 1'b0 || ps2_data_oe_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_oe: clk_oe=%b data_oe=%b required 0 0", ps2_clk_oe_o, ps2_data_oe_o);
    end
    checks++;
    if (ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_flags: ready=%b busy=%b required 1 0", ready_o, busy_o);
    end
    repeat (3) @(negedge clk);
    reset_n_i = 1'b1;
    bits.delete();
    edge_cyc.delete();
    repeat (600) @(negedge clk);
    checks++;
    if (bits.size() != 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_queue_empty: bits=%0d busy=%b required 0 0", bits.size(), busy_o);
    end
  endtask

  task automatic test_data_stability();
    checks++;
    if (stab_err != 0) begin
      errors++;
      $display("FAIL data_stable: got %0d changes while clock low required 0", stab_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_abort();
    test_stop_inhibit();
    test_data_stability();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
